debouncer_n: RTL and testbench



---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_channel.sv | 111 +++++++++++
 rtl/debouncer_n.sv | 68 ++++++
 tb/tb_debouncer_n.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and width helper for the N-channel debouncer.
package debounce_pkg;

   localparam int DEFAULT_TICK_DIV            = 100000;
   localparam int DEFAULT_STABLE_TICKS        = 10;
   localparam int DEFAULT_REPEAT_DELAY_TICKS  = 500;
   localparam int DEFAULT_REPEAT_PERIOD_TICKS = 100;

   // Bits needed to hold values 0..v-1; never less than 1.
   function automatic int cnt_width(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop sync, stability filter, press/release strobes.
// Optional autorepeat of the press strobe when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter bit INVERT       = 1'b0,
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
`ifdef DEBOUNCE_AUTOREPEAT_EN
  ,parameter int REPEAT_DELAY_TICKS  = DEFAULT_REPEAT_DELAY_TICKS
  ,parameter int REPEAT_PERIOD_TICKS = DEFAULT_REPEAT_PERIOD_TICKS
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   input  logic tick_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int CNT_W = cnt_width(STABLE_TICKS + 1);

   logic             s1_q, s1_d, s2_q, s2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             commit;
   logic             rpt_fire;

   // Sync chain and filter: any return to the committed level restarts the count.
   always_comb begin
      s1_d    = raw_i ^ INVERT;
      s2_d    = s1_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      commit  = 1'b0;
      if (s2_q == level_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
            commit  = 1'b1;
            level_d = s2_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int RPT_W = cnt_width(REPEAT_DELAY_TICKS + 1);

   logic [RPT_W-1:0] rpt_q, rpt_d;

   // Hold timer: first repeat after DELAY ticks, then reload so the next comes PERIOD later.
   always_comb begin
      rpt_d    = rpt_q;
      rpt_fire = 1'b0;
      if (!level_q || commit) begin
         rpt_d = '0;
      end else if (tick_i) begin
         if (rpt_q == RPT_W'(REPEAT_DELAY_TICKS - 1)) begin
            rpt_d    = RPT_W'(REPEAT_DELAY_TICKS - REPEAT_PERIOD_TICKS);
            rpt_fire = 1'b1;
         end else begin
            rpt_d = rpt_q + RPT_W'(1);
         end
      end
   end

   // Hold timer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rpt_q <= '0;
      else        rpt_q <= rpt_d;
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // Strobes land on the same edge as the level they announce.
   always_comb begin
      press_d   = (commit & s2_q) | rpt_fire;
      release_d = commit & ~s2_q;
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/debouncer_n.sv
// N-channel debouncer top: shared tick prescaler plus one debounce_channel per input.
// The release strobe port is named release_o since "release" is a reserved word.
// Define DEBOUNCE_AUTOREPEAT_EN to add press autorepeat while a channel is held.
module debouncer_n
   import debounce_pkg::*;
#(
   parameter int              N_CH                = 5,
   parameter int              TICK_DIV            = DEFAULT_TICK_DIV,
   parameter int              STABLE_TICKS        = DEFAULT_STABLE_TICKS,
   parameter logic [N_CH-1:0] ACTIVE_LOW          = '0,
   parameter int              REPEAT_DELAY_TICKS  = DEFAULT_REPEAT_DELAY_TICKS,
   parameter int              REPEAT_PERIOD_TICKS = DEFAULT_REPEAT_PERIOD_TICKS
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] release_o
);

   logic tick;

   // Reject configurations the filter and repeat timer cannot represent.
   if (STABLE_TICKS < 1 || TICK_DIV < 1 || REPEAT_PERIOD_TICKS < 1 ||
       REPEAT_PERIOD_TICKS > REPEAT_DELAY_TICKS) begin : g_bad_cfg
      $error("debouncer_n: invalid parameter set");
   end

   if (TICK_DIV == 1) begin : g_tick_always
      assign tick = 1'b1;
   end else begin : g_prescaler
      localparam int PRE_W = cnt_width(TICK_DIV);
      logic [PRE_W-1:0] pre_q, pre_d;

      // Free-running 0..TICK_DIV-1 counter; tick on the terminal count.
      always_comb begin
         tick  = (pre_q == PRE_W'(TICK_DIV - 1));
         pre_d = tick ? '0 : pre_q + PRE_W'(1);
      end

      // Prescaler register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) pre_q <= '0;
         else        pre_q <= pre_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .INVERT             (ACTIVE_LOW[i]),
         .STABLE_TICKS       (STABLE_TICKS)
`ifdef DEBOUNCE_AUTOREPEAT_EN
        ,.REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS)
        ,.REPEAT_PERIOD_TICKS(REPEAT_PERIOD_TICKS)
`endif
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw_i    (raw_in[i]),
         .tick_i   (tick),
         .level_o  (level[i]),
         .press_o  (press[i]),
         .release_o(release_o[i])
      );
   end

endmodule

// File: tb/tb_debouncer_n.sv
// Directed bench for debouncer_n: N_CH=3, TICK_DIV=1, STABLE_TICKS=4, ACTIVE_LOW=3'b100.
module tb_debouncer_n;

   logic       clk;
   logic       rst_n;
   logic [2:0] raw_in;
   logic [2:0] level;
   logic [2:0] press;
   logic [2:0] release_o;

   int checks   = 0;
   int failures = 0;

   debouncer_n #(
      .N_CH               (3),
      .TICK_DIV           (1),
      .STABLE_TICKS       (4),
      .ACTIVE_LOW         (3'b100),
      .REPEAT_DELAY_TICKS (8),
      .REPEAT_PERIOD_TICKS(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_in   (raw_in),
      .level    (level),
      .press    (press),
      .release_o(release_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Raw input has just changed: level must hold for 5 edges, commit on edge 6,
   // and the strobes must last exactly one cycle.
   task automatic commit(input string tag, input logic [2:0] lvl_old, input logic [2:0] lvl_new,
                         input logic [2:0] prs, input logic [2:0] rls);
      for (int e = 1; e <= 5; e++) begin
         edges(1);
         chk({tag, " wait level"}, level, lvl_old);
         chk({tag, " wait press"}, press, 3'b000);
         chk({tag, " wait release"}, release_o, 3'b000);
      end
      edges(1);
      chk({tag, " level"}, level, lvl_new);
      chk({tag, " press"}, press, prs);
      chk({tag, " release"}, release_o, rls);
      edges(1);
      chk({tag, " press end"}, press, 3'b000);
      chk({tag, " release end"}, release_o, 3'b000);
   endtask

   initial begin
      logic [2:0] exp_p;
      logic [2:0] exp_l;
      logic [2:0] exp_r;
      logic [4:0] bseq;

      // Reset held with inputs active: everything stays zero.
      rst_n  = 1'b0;
      raw_in = 3'b111;
      #1;
      chk("reset level", level, 3'b000);
      chk("reset press", press, 3'b000);
      chk("reset release", release_o, 3'b000);
      edges(3);
      chk("reset hold level", level, 3'b000);
      chk("reset hold press", press, 3'b000);
      chk("reset hold release", release_o, 3'b000);

`ifdef DEBOUNCE_AUTOREPEAT_EN
      // Leave reset idle, then hold channel 0 for 30 cycles after the commit.
      raw_in = 3'b100;
      rst_n  = 1'b1;
      edges(8);
      chk("ar idle level", level, 3'b000);
      raw_in = 3'b101;
      commit("ar commit", 3'b000, 3'b001, 3'b001, 3'b000);
      for (int k = 2; k <= 40; k++) begin
         if (k == 31) raw_in = 3'b100;
         edges(1);
         exp_p = (k < 36 && (k == 8 || (k > 8 && (k - 8) % 3 == 0))) ? 3'b001 : 3'b000;
         exp_l = (k < 36) ? 3'b001 : 3'b000;
         exp_r = (k == 36) ? 3'b001 : 3'b000;
         chk($sformatf("ar press k=%0d", k), press, exp_p);
         chk($sformatf("ar level k=%0d", k), level, exp_l);
         chk($sformatf("ar release k=%0d", k), release_o, exp_r);
      end
`else
      // Reset release with channels 0/1 held (channel 2 active-low, raw high = idle).
      rst_n = 1'b1;
      commit("rst release", 3'b000, 3'b011, 3'b011, 3'b000);

      // Clean release then press on channel 0, hold, release again.
      raw_in = 3'b110;
      commit("clean rel0", 3'b011, 3'b010, 3'b000, 3'b001);
      raw_in = 3'b111;
      commit("clean prs0", 3'b010, 3'b011, 3'b001, 3'b000);
      for (int k = 0; k < 20; k++) begin
         edges(1);
         chk("hold level", level, 3'b011);
         chk("hold strobes", press | release_o, 3'b000);
      end
      raw_in = 3'b110;
      commit("clean rel0b", 3'b011, 3'b010, 3'b000, 3'b001);
      raw_in = 3'b100;
      commit("rel1", 3'b010, 3'b000, 3'b000, 3'b010);

      // 3-cycle glitch on channel 1: never commits.
      raw_in = 3'b110;
      for (int k = 0; k < 11; k++) begin
         if (k == 3) raw_in = 3'b100;
         edges(1);
         chk("glitch3 level", level, 3'b000);
         chk("glitch3 press", press, 3'b000);
      end

      // 4-cycle pulse on channel 1: commits on edge 6, releases on edge 10.
      raw_in = 3'b110;
      for (int k = 1; k <= 11; k++) begin
         if (k == 5) raw_in = 3'b100;
         edges(1);
         exp_l = (k >= 6 && k < 10) ? 3'b010 : 3'b000;
         exp_p = (k == 6) ? 3'b010 : 3'b000;
         exp_r = (k == 10) ? 3'b010 : 3'b000;
         chk($sformatf("pulse4 level e=%0d", k), level, exp_l);
         chk($sformatf("pulse4 press e=%0d", k), press, exp_p);
         chk($sformatf("pulse4 release e=%0d", k), release_o, exp_r);
      end

      // Bounce on channel 0: 1,0,1,0 then a stable 1 gives a single press.
      bseq = 5'b01010;
      for (int k = 3; k >= 0; k--) begin
         raw_in = {2'b10, bseq[k]};
         edges(1);
         chk("bounce quiet", press | release_o, 3'b000);
      end
      raw_in = 3'b101;
      commit("bounce", 3'b000, 3'b001, 3'b001, 3'b000);
      raw_in = 3'b100;
      commit("bounce rel", 3'b001, 3'b000, 3'b000, 3'b001);

      // Simultaneous commits on all channels, then active-low channel 2 alone.
      raw_in = 3'b011;
      commit("simul prs", 3'b000, 3'b111, 3'b111, 3'b000);
      raw_in = 3'b100;
      commit("simul rel", 3'b111, 3'b000, 3'b000, 3'b111);
      raw_in = 3'b000;
      commit("active low", 3'b000, 3'b100, 3'b100, 3'b000);

      // Asynchronous reset in the middle of a release count: immediate zeros, no strobe.
      raw_in = 3'b100;
      edges(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst level", level, 3'b000);
      chk("mid rst press", press, 3'b000);
      chk("mid rst release", release_o, 3'b000);
      edges(2);
      chk("mid rst hold level", level, 3'b000);
      chk("mid rst hold strobes", press | release_o, 3'b000);

      // Channel 2 still active when reset lifts: commits once through the filter.
      raw_in = 3'b000;
      rst_n  = 1'b1;
      commit("post rst", 3'b000, 3'b100, 3'b100, 3'b000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
